// File: rtl/pacman_input_pkg.sv
// Shared constants and types for the pacman player-input conditioning stage.
// Joystick bit map, core input-byte positions and coin FSM states.
package pacman_input_pkg;

  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_START1 = 5;
  localparam int JB_START2 = 6;
  localparam int JB_COIN   = 7;
  localparam int JB_CHEAT  = 8;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  localparam int SYS_S1    = 0;
  localparam int SYS_S2    = 1;
  localparam int SYS_COIN  = 2;
  localparam int SYS_CHEAT = 3;

  localparam int IN0_UP    = 0;
  localparam int IN0_LEFT  = 1;
  localparam int IN0_RIGHT = 2;
  localparam int IN0_DOWN  = 3;
  localparam int IN0_CHEAT = 4;
  localparam int IN0_COIN  = 5;

  localparam int IN1_UP     = 0;
  localparam int IN1_LEFT   = 1;
  localparam int IN1_RIGHT  = 2;
  localparam int IN1_DOWN   = 3;
  localparam int IN1_START1 = 5;
  localparam int IN1_START2 = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  // Highest-priority rising direction: up > down > left > right.
  function automatic logic [3:0] pick_dir(
    input logic [3:0] v
  );
    logic [3:0] r;
    r = 4'b0000;
    if (v[DIR_UP])
      r[DIR_UP] = 1'b1;
    else if (v[DIR_DOWN])
      r[DIR_DOWN] = 1'b1;
    else if (v[DIR_LEFT])
      r[DIR_LEFT] = 1'b1;
    else if (v[DIR_RIGHT])
      r[DIR_RIGHT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/four_way_filter.sv
// 4-way direction arbiter: the most recently pressed held direction wins,
// falling back to the raw held set when that direction is released.
module four_way_filter
  import pacman_input_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dis,
  input  logic [3:0] q1,
  input  logic [3:0] rise,
  output logic [3:0] dir
);

  logic [3:0] r_mask;
  logic [3:0] w_mask_next;

  always_comb begin
    w_mask_next = r_mask;
    if (rise != 4'b0000)
      w_mask_next = pick_dir(rise);
    if (dis || ((q1 & w_mask_next) == 4'b0000))
      w_mask_next = 4'hF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= 4'hF;
      dir    <= 4'h0;
    end else begin
      r_mask <= w_mask_next;
      dir    <= q1 & w_mask_next;
    end
  end

endmodule

// File: rtl/pacman_input_cond.sv
// Conditions hps_io joystick words into the pacman core's active-low in0/in1
// bytes: 4-way arbitration, frame-timed coin pulses and start stretching.
module pacman_input_cond
  import pacman_input_pkg::*;
#(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 4,
  parameter int START_FRAMES = 2,
  parameter int QUEUE_MAX    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vblank,
  input  logic        dis_4way,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic        coin_busy
);

  localparam logic [3:0] C_COIN  = 4'(COIN_FRAMES - 1);
  localparam logic [3:0] C_GAP   = 4'(GAP_FRAMES - 1);
  localparam logic [3:0] C_START = 4'(START_FRAMES);
  localparam logic [2:0] C_QMAX  = 3'(QUEUE_MAX);

  logic [3:0] w_d1_in;
  logic [3:0] w_d2_in;
  logic [3:0] w_sys_in;
  logic       w_unused;

  assign w_d1_in = {joy1[JB_UP], joy1[JB_DOWN],
                    joy1[JB_LEFT], joy1[JB_RIGHT]};
  assign w_d2_in = {joy2[JB_UP], joy2[JB_DOWN],
                    joy2[JB_LEFT], joy2[JB_RIGHT]};
  assign w_sys_in = {joy1[JB_CHEAT]  | joy2[JB_CHEAT],
                     joy1[JB_COIN]   | joy2[JB_COIN],
                     joy1[JB_START2] | joy2[JB_START2],
                     joy1[JB_START1] | joy2[JB_START1]};
  assign w_unused = ^{joy1[15:9], joy1[4], joy2[15:9], joy2[4]};

  logic [3:0] r_d1_q1, r_d1_q2;
  logic [3:0] r_d2_q1, r_d2_q2;
  logic [3:0] r_sys_q1, r_sys_q2;
  logic       r_vblank_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d1_q1    <= 4'h0;
      r_d1_q2    <= 4'h0;
      r_d2_q1    <= 4'h0;
      r_d2_q2    <= 4'h0;
      r_sys_q1   <= 4'h0;
      r_sys_q2   <= 4'h0;
      r_vblank_q <= 1'b0;
    end else begin
      r_d1_q1    <= w_d1_in;
      r_d1_q2    <= r_d1_q1;
      r_d2_q1    <= w_d2_in;
      r_d2_q2    <= r_d2_q1;
      r_sys_q1   <= w_sys_in;
      r_sys_q2   <= r_sys_q1;
      r_vblank_q <= vblank;
    end
  end

  logic [3:0] w_d1_rise;
  logic [3:0] w_d2_rise;
  logic [2:0] w_sys_rise;
  logic       w_tick;

  assign w_d1_rise  = r_d1_q1 & ~r_d1_q2;
  assign w_d2_rise  = r_d2_q1 & ~r_d2_q2;
  assign w_sys_rise = r_sys_q1[2:0] & ~r_sys_q2[2:0];
  assign w_tick     = vblank & ~r_vblank_q;

  logic [3:0] w_dir1;
  logic [3:0] w_dir2;

  four_way_filter u_fw1 (
    .clk   (clk),
    .reset (reset),
    .dis   (dis_4way),
    .q1    (r_d1_q1),
    .rise  (w_d1_rise),
    .dir   (w_dir1)
  );

  four_way_filter u_fw2 (
    .clk   (clk),
    .reset (reset),
    .dis   (dis_4way),
    .q1    (r_d2_q1),
    .rise  (w_d2_rise),
    .dir   (w_dir2)
  );

  coin_state_t r_state, w_state_next;
  logic [3:0]  r_fcnt, w_fcnt_next;
  logic [2:0]  r_pend, w_pend_next;
  logic        w_inc;
  logic        w_dec;

  always_comb begin
    w_state_next = r_state;
    w_fcnt_next  = r_fcnt;
    w_dec        = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        IDLE: begin
          if (r_pend != 3'd0) begin
            w_state_next = PULSE;
            w_fcnt_next  = C_COIN;
            w_dec        = 1'b1;
          end
        end
        PULSE: begin
          if (r_fcnt == 4'd0) begin
            w_state_next = GAP;
            w_fcnt_next  = C_GAP;
          end else begin
            w_fcnt_next = r_fcnt - 4'd1;
          end
        end
        GAP: begin
          if (r_fcnt == 4'd0)
            w_state_next = IDLE;
          else
            w_fcnt_next = r_fcnt - 4'd1;
        end
        default: w_state_next = IDLE;
      endcase
    end
    // A press arriving with the queue full is lost, even if a coin leaves now.
    w_inc       = w_sys_rise[SYS_COIN] && (r_pend != C_QMAX);
    w_pend_next = r_pend + {2'b00, w_inc} - {2'b00, w_dec};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_fcnt  <= 4'd0;
      r_pend  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_fcnt  <= w_fcnt_next;
      r_pend  <= w_pend_next;
    end
  end

  logic [3:0] r_scnt [2];
  logic [3:0] w_scnt_next [2];
  logic [1:0] r_st;
  logic [1:0] w_st_next;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_scnt_next[i] = r_scnt[i];
      if (w_sys_rise[i])
        w_scnt_next[i] = C_START;
      else if (w_tick && (r_scnt[i] != 4'd0))
        w_scnt_next[i] = r_scnt[i] - 4'd1;
      w_st_next[i] = r_sys_q1[i] | (w_scnt_next[i] != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scnt[0] <= 4'd0;
      r_scnt[1] <= 4'd0;
      r_st      <= 2'b00;
    end else begin
      r_scnt[0] <= w_scnt_next[0];
      r_scnt[1] <= w_scnt_next[1];
      r_st      <= w_st_next;
    end
  end

  always_comb begin
    in0            = 8'hFF;
    in0[IN0_UP]    = ~w_dir1[DIR_UP];
    in0[IN0_LEFT]  = ~w_dir1[DIR_LEFT];
    in0[IN0_RIGHT] = ~w_dir1[DIR_RIGHT];
    in0[IN0_DOWN]  = ~w_dir1[DIR_DOWN];
    in0[IN0_CHEAT] = ~r_sys_q2[SYS_CHEAT];
    in0[IN0_COIN]  = ~(r_state == PULSE);
    in1             = 8'hFF;
    in1[IN1_UP]     = ~w_dir2[DIR_UP];
    in1[IN1_LEFT]   = ~w_dir2[DIR_LEFT];
    in1[IN1_RIGHT]  = ~w_dir2[DIR_RIGHT];
    in1[IN1_DOWN]   = ~w_dir2[DIR_DOWN];
    in1[IN1_START1] = ~r_st[SYS_S1];
    in1[IN1_START2] = ~r_st[SYS_S2];
  end

  assign coin_busy = (r_state != IDLE) || (r_pend != 3'd0);

endmodule

// File: tb/tb_pacman_input_cond.sv
// Randomized and directed bench for pacman_input_cond against a
// frame-level behavioural model of the input conditioning rules.
module tb_pacman_input_cond;

  localparam int COIN_F  = 4;
  localparam int GAP_F   = 4;
  localparam int START_F = 2;
  localparam int QMAX    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        vblank;
  logic        dis_4way;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        coin_busy;

  always #5 clk = ~clk;

  pacman_input_cond #(
    .COIN_FRAMES  (COIN_F),
    .GAP_FRAMES   (GAP_F),
    .START_FRAMES (START_F),
    .QUEUE_MAX    (QMAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vblank    (vblank),
    .dis_4way  (dis_4way),
    .joy1      (joy1),
    .joy2      (joy2),
    .in0       (in0),
    .in1       (in1),
    .coin_busy (coin_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int vper    = 60;
  bit vauto   = 1'b0;

  logic [3:0] m_q1d [2];
  logic [3:0] m_q2d [2];
  logic [3:0] m_dir [2];
  int         m_last [2];
  int         m_sc [2];
  logic [2:0] m_q1s, m_q2s;
  logic       m_q1ch, m_ch, m_vq;
  logic [1:0] m_st;
  int         m_pend, m_pl, m_gl;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic m_clear();
    for (int p = 0; p < 2; p++) begin
      m_q1d[p] = '0; m_q2d[p] = '0; m_dir[p] = '0;
      m_last[p] = -1; m_sc[p] = 0;
    end
    m_q1s = '0; m_q2s = '0; m_q1ch = 0; m_ch = 0; m_vq = 0;
    m_st = '0; m_pend = 0; m_pl = 0; m_gl = 0;
  endtask

  function automatic logic [7:0] exp_in0();
    return {2'b11, (m_pl > 0) ? 1'b0 : 1'b1, ~m_ch,
            ~m_dir[0][2], ~m_dir[0][0], ~m_dir[0][1], ~m_dir[0][3]};
  endfunction

  function automatic logic [7:0] exp_in1();
    return {1'b1, ~m_st[1], ~m_st[0], 1'b1,
            ~m_dir[1][2], ~m_dir[1][0], ~m_dir[1][1], ~m_dir[1][3]};
  endfunction

  // One clock: advance the model on the current inputs, then check the DUT.
  task automatic step();
    logic       tick;
    logic [3:0] r;
    logic [3:0] nd [2];
    logic [2:0] rs;
    int         inc;
    int         dec;
    if (vauto) vblank = (cyc % vper) < 3;
    if (reset) begin
      m_clear();
    end else begin
      tick = vblank && !m_vq;
      for (int p = 0; p < 2; p++) begin
        r = m_q1d[p] & ~m_q2d[p];
        for (int b = 0; b < 4; b++) if (r[b]) m_last[p] = b;
        if (dis_4way || m_last[p] < 0 || !m_q1d[p][m_last[p]]) begin
          m_last[p] = -1;
          nd[p] = m_q1d[p];
        end else begin
          nd[p] = 4'b0001 << m_last[p];
        end
      end
      rs  = m_q1s & ~m_q2s;
      inc = (rs[2] && m_pend < QMAX) ? 1 : 0;
      dec = 0;
      if (tick) begin
        if (m_pl > 0) begin
          m_pl--;
          if (m_pl == 0) m_gl = GAP_F;
        end else if (m_gl > 0) begin
          m_gl--;
        end else if (m_pend > 0) begin
          dec = 1;
          m_pl = COIN_F;
        end
      end
      m_pend = m_pend + inc - dec;
      for (int s = 0; s < 2; s++) begin
        if (rs[s]) m_sc[s] = START_F;
        else if (tick && m_sc[s] > 0) m_sc[s]--;
        m_st[s] = m_q1s[s] || (m_sc[s] > 0);
      end
      m_ch = m_q1ch;
      m_dir[0] = nd[0];
      m_dir[1] = nd[1];
      m_q2d[0] = m_q1d[0];
      m_q2d[1] = m_q1d[1];
      m_q2s = m_q1s;
      m_q1d[0] = joy1[3:0];
      m_q1d[1] = joy2[3:0];
      m_q1s = joy1[7:5] | joy2[7:5];
      m_q1ch = joy1[8] | joy2[8];
      m_vq = vblank;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("in0", in0, exp_in0());
    chk("in1", in1, exp_in1());
    chk("busy", coin_busy, (m_pl > 0 || m_gl > 0 || m_pend > 0));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic sync_frame();
    while (cyc % vper != 5) step();
  endtask

  task automatic count_pulses(input int budget, output int pulses,
                              output bit done);
    logic prev;
    prev = in0[5];
    pulses = 0;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (prev && !in0[5]) pulses++;
      prev = in0[5];
      if (!coin_busy && in0[5]) done = 1'b1;
    end
  endtask

  initial begin
    int first_low, low, clr, pulses;
    bit done;
    m_clear();
    reset = 1'b1; vblank = 1'b1; dis_4way = 1'b1;
    joy1 = '1; joy2 = '1;
    repeat (3) begin
      step();
      chk("rst_in0", in0, 8'hFF);
      chk("rst_in1", in1, 8'hFF);
      chk("rst_busy", coin_busy, 1'b0);
    end
    joy1 = '0; joy2 = '0; dis_4way = 1'b0;
    reset = 1'b0; vauto = 1'b1; vper = 60;
    run(5);

    joy1 = 16'h0001; run(10);
    joy1 = 16'h0009; run(2);
    chk("4w_up", in0[3:0], 4'b1110);
    joy1 = 16'h0001; run(2);
    chk("4w_right", in0[3:0], 4'b1011);
    joy1 = 16'h0000; run(4);
    dis_4way = 1'b1;
    joy1 = 16'h0001; run(10);
    joy1 = 16'h0009; run(2);
    chk("8w_both", in0[3:0], 4'b1010);
    joy1 = 16'h0000; dis_4way = 1'b0; run(4);

    sync_frame();
    joy1 = 16'h0080; run(2); joy1 = 16'h0000;
    first_low = -1; low = 0; clr = -1;
    for (int i = 0; i < 2000 && clr < 0; i++) begin
      step();
      if (!in0[5]) begin
        low++;
        if (first_low < 0) first_low = cyc;
      end
      if (first_low >= 0 && !coin_busy) clr = cyc;
    end
    chk("coin_phase", first_low % 60, 1);
    chk("coin_len", low, COIN_F * 60);
    chk("coin_clear", clr - first_low, (COIN_F + GAP_F) * 60);

    sync_frame();
    repeat (5) begin
      joy2 = 16'h0080; run(2); joy2 = 16'h0000; run(2);
    end
    count_pulses(4000, pulses, done);
    chk("queue_done", done, 1'b1);
    chk("queue_pulses", pulses, QMAX);

    sync_frame();
    repeat (2) begin
      joy1 = 16'h0080; run(2); joy1 = 16'h0000; run(2);
    end
    while (cyc % vper != 59) step();
    joy2 = 16'h0080; step(); joy2 = 16'h0000;
    count_pulses(4000, pulses, done);
    chk("same_done", done, 1'b1);
    chk("same_pulses", pulses, 3);

    sync_frame();
    joy1 = 16'h0020; step(); joy1 = 16'h0000;
    low = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!in1[5]) low++;
      else if (low > 0) break;
    end
    chk("st_len", low, 2 * 60 - 6);
    joy1 = 16'h0020; run(300); joy1 = 16'h0000;
    step();
    chk("st_hold", in1[5], 1'b0);
    step();
    chk("st_rel", in1[5], 1'b1);

    sync_frame();
    repeat (3) begin
      joy2 = 16'h0080; run(2); joy2 = 16'h0000; run(2);
    end
    for (int i = 0; i < 200 && in0[5]; i++) step();
    run(120);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rstp_coin", in0[5], 1'b1);
    chk("rstp_busy", coin_busy, 1'b0);
    low = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (!in0[5]) low++;
    end
    chk("rstp_none", low, 0);

    for (int blk = 0; blk < 20; blk++) begin
      vper = $urandom_range(5, 12);
      vauto = ($urandom_range(0, 4) != 0);
      if (!vauto) vblank = 1'($urandom_range(0, 1));
      dis_4way = 1'($urandom_range(0, 1));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 7) == 0)
          joy1 ^= 16'(1) << $urandom_range(0, 15);
        if ($urandom_range(0, 7) == 0)
          joy2 ^= 16'(1) << $urandom_range(0, 15);
        reset = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    reset = 1'b0;
    run(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
